conv_window_scheduler: RTL
==========================

Name: conv_window_scheduler

Overview:
- Sequences the sliding-window read schedule of the convolution accelerator.
- For each output pixel, emits K*K input-RAM addresses paired with the matching filter-ROM coefficient indices.
- Sits between the top-level accelerator FSM (start/busy/done) and the input RAM / filter ROM ports.
- Uses a valid/ready handshake so the multiplier/adder-tree datapath can stall it.

Parameters:
- IMG_W, 16, input matrix width = height (square image), row-major in RAM.
- K, 3, filter size (KxK), stride fixed at 1, no padding.
- ADDR_W, 10, input RAM address width; IMG_W*IMG_W must be <= 2**ADDR_W.
- COEF_W, 4, filter ROM address width; K*K must be <= 2**COEF_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled only in IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse when the whole frame is issued.
- tap_valid  out  1  tap_addr/coef_addr/win_first/win_last are valid.
- tap_ready  in  1  datapath accepts the current tap.
- ram_en  out  1  input RAM enable; equals tap_valid & tap_ready.
- tap_addr  out  ADDR_W  input RAM address.
- coef_addr  out  COEF_W  filter ROM address, row-major kr*K+kc.
- win_first  out  1  current tap is the first (kr=0,kc=0) of a window.
- win_last  out  1  current tap is the last (kr=kc=K-1) of a window.
- out_row  out  ADDR_W  output row r of the current window.
- out_col  out  ADDR_W  output column c of the current window.

Behaviour:
- OUT_W = IMG_W-K+1. The frame has OUT_W*OUT_W windows and OUT_W*OUT_W*K*K taps.
- Reset: state IDLE. All outputs 0, all counters 0. Reset is asynchronous and takes effect mid-frame; no done is issued after an aborted frame.
- FSM has two states, IDLE and RUN.
  - IDLE -> RUN when start=1.
  - RUN -> IDLE on acceptance (tap_valid & tap_ready) of the last tap of the last window.
- Latency: start high at edge N gives busy=1, tap_valid=1, tap_addr=0, coef_addr=0, win_first=1 after edge N.
- Tap order: windows in raster order (r outer, c inner). Within a window, kr outer, kc inner.
  - tap_addr = (r+kr)*IMG_W + (c+kc).
  - Computed incrementally from registered base pointers; no multiplier.
- Handshake:
  - Counters advance only on acceptance.
  - While tap_valid=1 and tap_ready=0, every output holds stable.
  - tap_ready is ignored while tap_valid=0.
  - tap_valid stays 1 continuously in RUN, with no bubbles between windows or rows.
- Last-tap acceptance: on that edge, tap_valid, busy, win_last and all address outputs go to 0, and done=1 for exactly one cycle.
- done is asserted only in IDLE, never together with busy.
- start while busy is ignored. start held high in IDLE after done begins a new frame on the next edge, with done and busy each one cycle apart.
- All outputs are registered; ram_en is the only combinational output.
- Widths:
  - The counters kr and kc hold 0..K-1.
  - The counters r and c hold 0..OUT_W-1.
  - Address arithmetic never exceeds IMG_W*IMG_W-1 and never wraps.
- K=1 is legal: win_first = win_last = 1 on every tap, and coef_addr is always 0.

Test Plan:
- IMG_W=4, K=3, tap_ready=1 tied, start pulse -> 36 taps on consecutive cycles, done 1 cycle after the 36th, then busy=0.
  - Window (0,0) addresses: 0,1,2,4,5,6,8,9,10.
  - Window (0,1) addresses: 1,2,3,5,6,7,9,10,11.
  - Window (1,0) starts at 4.
  - Window (1,1) ends at 15.
- Same setup: coef_addr cycles 0..8 per window. win_first is set on coef 0, win_last on coef 8. out_row/out_col step (0,0),(0,1),(1,0),(1,1).
- Random tap_ready with 50% duty -> identical accepted sequence to the previous scenario. Outputs stay frozen through every stall cycle. ram_en is high only on accepted cycles.
- start pulsed again at tap 10 while busy -> no effect; exactly 36 taps and a single done.
- reset asserted at tap 20 with tap_ready=0 -> outputs are 0 immediately (asynchronously). After release and a new start, the frame restarts at tap_addr=0 and no done appears before the new frame ends.
- Defaults IMG_W=16, K=3, start held high -> 14*14*9=1764 taps.
  - Last tap_addr is 255, last coef_addr is 8.
  - done is followed one cycle later by busy=1 for a second frame.

Source files
------------

// File: rtl/conv_window_scheduler.sv
// Sliding-window read scheduler: for every output pixel emits K*K input-RAM
// addresses and matching filter-ROM indices over a valid/ready handshake.
module conv_window_scheduler #(
  parameter int IMG_W  = 16,
  parameter int K      = 3,
  parameter int ADDR_W = 10,
  parameter int COEF_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] tap_addr,
  output logic [COEF_W-1:0] coef_addr,
  output logic              win_first,
  output logic              win_last,
  output logic [ADDR_W-1:0] out_row,
  output logic [ADDR_W-1:0] out_col
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [KW-1:0]     K_LAST    = KW'(K - 1);
  localparam logic [ADDR_W-1:0] O_LAST    = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(K);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [KW-1:0]       kr_q, kr_d, kc_q, kc_d;
  logic [ADDR_W-1:0]   r_q, r_d, c_q, c_d;
  logic [ADDR_W-1:0]   win_base_q, win_base_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic                first_q, first_d, last_q, last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      kr_q       <= '0;
      kc_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      win_base_q <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      coef_q     <= '0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      r_q        <= r_d;
      c_q        <= c_d;
      win_base_q <= win_base_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      coef_q     <= coef_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    kr_d       = kr_q;
    kc_d       = kc_q;
    r_d        = r_q;
    c_d        = c_q;
    win_base_d = win_base_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    coef_d     = coef_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          kr_d       = '0;
          kc_d       = '0;
          r_d        = '0;
          c_d        = '0;
          win_base_d = '0;
          row_base_d = '0;
          addr_d     = '0;
          coef_d     = '0;
        end
      end
      S_RUN: begin
        if (tap_ready) begin
          if (kc_q != K_LAST) begin
            kc_d   = kc_q + KW'(1);
            addr_d = addr_q + ADDR_W'(1);
            coef_d = coef_q + COEF_W'(1);
          end else if (kr_q != K_LAST) begin
            kc_d       = '0;
            kr_d       = kr_q + KW'(1);
            row_base_d = row_base_q + ROW_STEP;
            addr_d     = row_base_q + ROW_STEP;
            coef_d     = coef_q + COEF_W'(1);
          end else begin
            kc_d   = '0;
            kr_d   = '0;
            coef_d = '0;
            // Window base moves right by one, or from the last column to the
            // start of the next row: (r*W + OUT_W-1) + K == (r+1)*W.
            if (c_q != O_LAST) begin
              c_d        = c_q + ADDR_W'(1);
              win_base_d = win_base_q + ADDR_W'(1);
            end else if (r_q != O_LAST) begin
              c_d        = '0;
              r_d        = r_q + ADDR_W'(1);
              win_base_d = win_base_q + WRAP_STEP;
            end else begin
              state_d    = S_IDLE;
              done_d     = 1'b1;
              r_d        = '0;
              c_d        = '0;
              win_base_d = '0;
            end
            row_base_d = win_base_d;
            addr_d     = win_base_d;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    first_d = (state_d == S_RUN) && (kr_d == '0) && (kc_d == '0);
    last_d  = (state_d == S_RUN) && (kr_d == K_LAST) && (kc_d == K_LAST);
  end

  assign busy      = (state_q == S_RUN);
  assign tap_valid = (state_q == S_RUN);
  assign done      = done_q;
  assign ram_en    = tap_valid & tap_ready;
  assign tap_addr  = addr_q;
  assign coef_addr = coef_q;
  assign win_first = first_q;
  assign win_last  = last_q;
  assign out_row   = r_q;
  assign out_col   = c_q;

endmodule
